// File: rtl/fetch_pc_seq.sv
// Fetch-address sequencer: owns IFA, merges BTB predictions, a circular
// return-address stack and execute-stage redirects into the next fetch address.
module fetch_pc_seq #(
  parameter int unsigned    AW        = 14,
  parameter int unsigned    RAS_DEPTH = 4,
  parameter int unsigned    FLUSH_CYC = 1,
  parameter logic [AW-1:0]  RESET_PC  = '0
) (
  input  logic          DSPCLK,
  input  logic          T_RST,
  input  logic          GO_F,
  input  logic          BTaken_I,
  input  logic          RTaken_I,
  input  logic [AW-1:0] Bt_I,
  input  logic          CALL_I,
  input  logic          Redir_E,
  input  logic [AW-1:0] RedirA_E,
  output logic [AW-1:0] IFA,
  output logic [AW-1:0] IFA_nx,
  output logic          PPclr_h,
  output logic          RAS_empty,
  output logic          RAS_full
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {RST_S, RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic [AW-1:0]   ifa_q, ifa_d;
  logic            ppclr_q, ppclr_d;
  logic [PW-1:0]   ras_ptr_q, ras_ptr_d;
  logic [CW-1:0]   ras_cnt_q, ras_cnt_d;
  logic [AW-1:0]   ras_mem_q [RAS_DEPTH];
  logic [AW-1:0]   ras_mem_d [RAS_DEPTH];

  logic            ras_empty, ras_full, ras_en, do_push, do_pop, running;
  logic [AW-1:0]   seq_pc, ras_top;

  assign ras_empty = (ras_cnt_q == '0);
  assign ras_full  = (ras_cnt_q == CW'(RAS_DEPTH));
  assign running   = (state_q == RUN);
  assign seq_pc    = ifa_q + AW'(1);
  assign ras_top   = ras_mem_q[ras_ptr_q];
  assign ras_en    = GO_F && running && !Redir_E;
  assign do_push   = ras_en && CALL_I;
  assign do_pop    = ras_en && RTaken_I && !ras_empty;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      RST_S:   state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH: begin
        if (flush_cnt_q == '0) state_d = RUN;
        else                   flush_cnt_d = flush_cnt_q - 3'd1;
      end
      default: state_d = RST_S;
    endcase
    if (Redir_E) begin
      state_d     = FLUSH;
      flush_cnt_d = 3'(FLUSH_CYC - 1);
    end
  end

  // Pipeline clear is a registered decode of the next state, so no input reaches PPclr_h combinationally.
  assign ppclr_d = (state_d != RUN);

  always_comb begin
    ifa_d = seq_pc;
    if (Redir_E)                   ifa_d = RedirA_E;
    else if (!GO_F || !running)    ifa_d = ifa_q;
    else if (RTaken_I && !ras_empty) ifa_d = ras_top;
    else if (BTaken_I)             ifa_d = Bt_I;
  end

  // The pointer marks the top; a push into a full stack wraps onto the oldest slot.
  always_comb begin
    ras_mem_d = ras_mem_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (do_push && do_pop) begin
      ras_mem_d[ras_ptr_q] = seq_pc;
    end else if (do_push) begin
      ras_ptr_d            = ras_ptr_q + PW'(1);
      ras_mem_d[ras_ptr_d] = seq_pc;
      if (!ras_full) ras_cnt_d = ras_cnt_q + CW'(1);
    end else if (do_pop) begin
      ras_ptr_d = ras_ptr_q - PW'(1);
      ras_cnt_d = ras_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge DSPCLK or posedge T_RST) begin
    if (T_RST) begin
      state_q     <= RST_S;
      flush_cnt_q <= '0;
      ifa_q       <= RESET_PC;
      ppclr_q     <= 1'b1;
      ras_ptr_q   <= '0;
      ras_cnt_q   <= '0;
      ras_mem_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      ifa_q       <= ifa_d;
      ppclr_q     <= ppclr_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_cnt_q   <= ras_cnt_d;
      ras_mem_q   <= ras_mem_d;
    end
  end

  assign IFA       = ifa_q;
  assign IFA_nx    = ifa_d;
  assign PPclr_h   = ppclr_q;
  assign RAS_empty = ras_empty;
  assign RAS_full  = ras_full;

endmodule

// File: tb/tb_fetch_pc_seq.sv
// Self-checking bench for fetch_pc_seq: directed spec scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_fetch_pc_seq;

  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic        clk = 1'b0;
  logic        rst, go, bt, rt, call, redir;
  logic [13:0] bt_a, redir_a;
  logic [13:0] ifa, ifa_nx;
  logic        ppclr, ras_empty, ras_full;

  int checks = 0;
  int failures = 0;

  // Behavioural model: reset-cycle flag, remaining flush cycles, RAS as a queue.
  logic [13:0] m_ifa;
  bit          m_rstc;
  int          m_fl;
  logic [13:0] m_ras [$];

  fetch_pc_seq #(.AW(14), .RAS_DEPTH(DEPTH), .FLUSH_CYC(FC), .RESET_PC(14'h0)) dut (
    .DSPCLK(clk), .T_RST(rst), .GO_F(go), .BTaken_I(bt), .RTaken_I(rt), .Bt_I(bt_a),
    .CALL_I(call), .Redir_E(redir), .RedirA_E(redir_a), .IFA(ifa), .IFA_nx(ifa_nx),
    .PPclr_h(ppclr), .RAS_empty(ras_empty), .RAS_full(ras_full));

  always #5 clk = ~clk;

  function automatic logic [13:0] m_nx();
    if (redir) return redir_a;
    if (!go || m_rstc || m_fl > 0) return m_ifa;
    if (rt && m_ras.size() > 0) return m_ras[m_ras.size()-1];
    if (bt) return bt_a;
    return m_ifa + 14'd1;
  endfunction

  task automatic set_in(input logic g, input logic b, input logic [13:0] ba,
                        input logic r, input logic c, input logic rd, input logic [13:0] ra);
    go = g; bt = b; bt_a = ba; rt = r; call = c; redir = rd; redir_a = ra;
  endtask

  task automatic idle();
    set_in(1'b1, 1'b0, 14'h0, 1'b0, 1'b0, 1'b0, 14'h0);
  endtask

  task automatic tick();
    logic [13:0] nx;
    bit running, push, pop;
    @(posedge clk);
    nx = m_nx();
    running = !m_rstc && m_fl == 0;
    push = go && running && !redir && call;
    pop  = go && running && !redir && rt && m_ras.size() > 0;
    if (push && pop) m_ras[m_ras.size()-1] = m_ifa + 14'd1;
    else if (push) begin
      m_ras.push_back(m_ifa + 14'd1);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end else if (pop) void'(m_ras.pop_back());
    if (redir) begin m_fl = FC; m_rstc = 0; end
    else if (m_rstc) m_rstc = 0;
    else if (m_fl > 0) m_fl--;
    m_ifa = nx;
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_ifa = 14'h0; m_rstc = 1; m_fl = 0; m_ras.delete();
  endtask

  task automatic redirect_to(input logic [13:0] a);
    set_in(1'b1, 1'b0, 14'h0, 1'b0, 1'b0, 1'b1, a);
    tick();
    idle();
    repeat (FC) tick();
  endtask

  task automatic test_reset();
    logic [13:0] exp_ifa [4];
    logic        exp_clr [4];
    exp_ifa = '{14'h0, 14'h0, 14'h1, 14'h2};
    exp_clr = '{1'b1, 1'b0, 1'b0, 1'b0};
    rst = 1'b1; idle();
    #2;
    checks++; if (ifa !== 14'h0 || ppclr !== 1'b1 || ras_empty !== 1'b1 || ras_full !== 1'b0) begin
      failures++; $display("FAIL reset_state got ifa=%h clr=%b e=%b f=%b exp 0000/1/1/0", ifa, ppclr, ras_empty, ras_full);
    end
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ifa !== exp_ifa[i] || ppclr !== exp_clr[i]) begin
        failures++; $display("FAIL reset_seq[%0d] got ifa=%h clr=%b exp ifa=%h clr=%b", i, ifa, ppclr, exp_ifa[i], exp_clr[i]);
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    redirect_to(14'h3FFE);
    checks++; if (ifa !== 14'h3FFE || ppclr !== 1'b0) begin
      failures++; $display("FAIL wrap_start got ifa=%h clr=%b exp ifa=3ffe clr=0", ifa, ppclr);
    end
    tick();
    checks++; if (ifa !== 14'h3FFF) begin failures++; $display("FAIL wrap_3fff got=%h exp=3fff", ifa); end
    tick();
    checks++; if (ifa !== 14'h0000) begin failures++; $display("FAIL wrap_0000 got=%h exp=0000", ifa); end
  endtask

  task automatic test_branch();
    redirect_to(14'h0010);
    set_in(1'b1, 1'b1, 14'h0123, 1'b0, 1'b0, 1'b0, 14'h0);
    #1;
    checks++; if (ifa_nx !== 14'h0123) begin failures++; $display("FAIL branch_nx got=%h exp=0123", ifa_nx); end
    tick();
    checks++; if (ifa !== 14'h0123) begin failures++; $display("FAIL branch_ifa got=%h exp=0123", ifa); end
    idle(); tick();
    checks++; if (ifa !== 14'h0124) begin failures++; $display("FAIL branch_seq got=%h exp=0124", ifa); end
    go = 1'b0;
    repeat (2) tick();
    checks++; if (ifa !== 14'h0124) begin failures++; $display("FAIL branch_hold got=%h exp=0124", ifa); end
  endtask

  task automatic test_call_return();
    redirect_to(14'h0040);
    set_in(1'b1, 1'b1, 14'h0200, 1'b0, 1'b1, 1'b0, 14'h0);
    tick();
    checks++; if (ifa !== 14'h0200 || ras_empty !== 1'b0) begin
      failures++; $display("FAIL call_push got ifa=%h e=%b exp ifa=0200 e=0", ifa, ras_empty);
    end
    idle(); repeat (5) tick();
    rt = 1'b1; #1;
    checks++; if (ifa !== 14'h0205 || ifa_nx !== 14'h0041) begin
      failures++; $display("FAIL ret_nx got ifa=%h nx=%h exp ifa=0205 nx=0041", ifa, ifa_nx);
    end
    tick();
    checks++; if (ifa !== 14'h0041 || ras_empty !== 1'b1) begin
      failures++; $display("FAIL ret_pop got ifa=%h e=%b exp ifa=0041 e=1", ifa, ras_empty);
    end
    idle(); redirect_to(14'h0205);
    rt = 1'b1; tick();
    checks++; if (ifa !== 14'h0206) begin failures++; $display("FAIL ret_empty got=%h exp=0206", ifa); end
  endtask

  task automatic test_redirect();
    set_in(1'b0, 1'b1, 14'h0123, 1'b0, 1'b0, 1'b1, 14'h0300);
    #1;
    checks++; if (ifa_nx !== 14'h0300) begin failures++; $display("FAIL redir_nx got=%h exp=0300", ifa_nx); end
    tick();
    checks++; if (ifa !== 14'h0300 || ppclr !== 1'b1) begin
      failures++; $display("FAIL redir_ifa got ifa=%h clr=%b exp ifa=0300 clr=1", ifa, ppclr);
    end
    set_in(1'b1, 1'b1, 14'h0123, 1'b0, 1'b0, 1'b0, 14'h0);
    tick();
    checks++; if (ifa !== 14'h0300 || ppclr !== 1'b1) begin
      failures++; $display("FAIL flush_hold got ifa=%h clr=%b exp ifa=0300 clr=1", ifa, ppclr);
    end
    redir = 1'b1; redir_a = 14'h0400;
    tick();
    redir = 1'b0;
    checks++; if (ifa !== 14'h0400 || ppclr !== 1'b1) begin
      failures++; $display("FAIL reflush got ifa=%h clr=%b exp ifa=0400 clr=1", ifa, ppclr);
    end
    tick();
    checks++; if (ppclr !== 1'b1) begin failures++; $display("FAIL reflush_len got=%b exp=1", ppclr); end
    tick();
    checks++; if (ifa !== 14'h0400 || ppclr !== 1'b0) begin
      failures++; $display("FAIL flush_end got ifa=%h clr=%b exp ifa=0400 clr=0", ifa, ppclr);
    end
    tick();
    checks++; if (ifa !== 14'h0123) begin failures++; $display("FAIL post_flush_bt got=%h exp=0123", ifa); end
    idle();
  endtask

  task automatic test_ras_overflow();
    logic [13:0] exp_pop [4];
    exp_pop = '{14'h0051, 14'h0041, 14'h0031, 14'h0021};
    reset_dut(); tick();
    redirect_to(14'h0010);
    for (int k = 1; k <= 5; k++) begin
      set_in(1'b1, 1'b1, 14'(16 * k + 16), 1'b0, 1'b1, 1'b0, 14'h0);
      tick();
      if (k == 3 || k == 4) begin
        checks++; if (ras_full !== (k == 4)) begin
          failures++; $display("FAIL ras_full[%0d] got=%b exp=%b", k, ras_full, k == 4);
        end
      end
    end
    set_in(1'b1, 1'b0, 14'h0, 1'b1, 1'b0, 1'b0, 14'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ifa !== exp_pop[k] || ras_empty !== (k == 3)) begin
        failures++; $display("FAIL ras_pop[%0d] got ifa=%h e=%b exp ifa=%h e=%b", k, ifa, ras_empty, exp_pop[k], k == 3);
      end
    end
    idle();
  endtask

  task automatic test_call_ret_same();
    redirect_to(14'h0040);
    set_in(1'b1, 1'b1, 14'h0100, 1'b0, 1'b1, 1'b0, 14'h0);
    tick();
    set_in(1'b1, 1'b0, 14'h0, 1'b1, 1'b1, 1'b0, 14'h0);
    #1;
    checks++; if (ifa_nx !== 14'h0041) begin failures++; $display("FAIL callret_nx got=%h exp=0041", ifa_nx); end
    tick();
    checks++; if (ifa !== 14'h0041 || ras_empty !== 1'b0) begin
      failures++; $display("FAIL callret_cnt got ifa=%h e=%b exp ifa=0041 e=0", ifa, ras_empty);
    end
    call = 1'b0;
    tick();
    checks++; if (ifa !== 14'h0101 || ras_empty !== 1'b1) begin
      failures++; $display("FAIL callret_top got ifa=%h e=%b exp ifa=0101 e=1", ifa, ras_empty);
    end
    idle();
  endtask

  task automatic test_async_reset();
    redirect_to(14'h0500);
    set_in(1'b1, 1'b0, 14'h0, 1'b0, 1'b1, 1'b0, 14'h0);
    tick();
    set_in(1'b1, 1'b0, 14'h0, 1'b0, 1'b0, 1'b1, 14'h0777);
    tick();
    idle();
    #2 rst = 1'b1;
    #1;
    checks++; if (ifa !== 14'h0 || ras_empty !== 1'b1 || ppclr !== 1'b1) begin
      failures++; $display("FAIL async_rst got ifa=%h e=%b clr=%b exp 0000/1/1", ifa, ras_empty, ppclr);
    end
    reset_dut();
  endtask

  task automatic test_random();
    tick();
    for (int n = 0; n < 2000; n++) begin
      set_in(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0), 14'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 29) == 0), 14'($urandom));
      #1;
      checks++; if (ifa_nx !== m_nx()) begin
        failures++; $display("FAIL rnd_nx[%0d] got=%h exp=%h", n, ifa_nx, m_nx());
      end
      tick();
      checks++; if (ifa !== m_ifa || ppclr !== (m_rstc || m_fl > 0) ||
                    ras_empty !== (m_ras.size() == 0) || ras_full !== (m_ras.size() == DEPTH)) begin
        failures++;
        $display("FAIL rnd_state[%0d] got ifa=%h clr=%b e=%b f=%b exp ifa=%h clr=%b e=%b f=%b", n,
                 ifa, ppclr, ras_empty, ras_full, m_ifa, (m_rstc || m_fl > 0),
                 (m_ras.size() == 0), (m_ras.size() == DEPTH));
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_branch();
    test_call_return();
    test_redirect();
    test_ras_overflow();
    test_call_ret_same();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
